// File: rtl/tlb_pkg.sv
// Shared TLB constants, entry layout and the tag/page-select helpers used by the table.
package tlb_pkg;
   localparam int PS_4K  = 12;
   localparam int PS_4M  = 22;
   localparam int PS_MIN = 12;
   localparam int PS_MAX = 29;

   localparam int unsigned VPPN_W = 19;
   localparam int unsigned PPN_W  = 20;
   localparam int unsigned PS_W   = 6;
   localparam int unsigned ASID_W = 10;
   localparam int unsigned PLV_W  = 2;
   localparam int unsigned MAT_W  = 2;
   localparam int unsigned OP_W   = 5;

   typedef enum logic [OP_W-1:0] {
      InvAll0           = 5'd0,
      InvAll1           = 5'd1,
      InvGlobal         = 5'd2,
      InvNonGlobal      = 5'd3,
      InvAsid           = 5'd4,
      InvAsidVa         = 5'd5,
      InvGlobalOrAsidVa = 5'd6
   } inv_op_e;

   localparam logic [OP_W-1:0] INV_OP_MAX = 5'd6;

   typedef struct packed {
      logic [PPN_W-1:0] ppn;
      logic [PLV_W-1:0] plv;
      logic [MAT_W-1:0] mat;
      logic             d;
      logic             v;
   } page_t;

   typedef struct packed {
      logic [VPPN_W-1:0] vppn;
      logic [PS_W-1:0]   ps;
      logic [ASID_W-1:0] asid;
      logic              g;
      page_t             p0;
      page_t             p1;
   } entry_t;

   function automatic logic ps_legal(logic [PS_W-1:0] ps);
      return int'(ps) >= PS_MIN && int'(ps) <= PS_MAX;
   endfunction

   // Compare vppn[18:ps-12]; bits below the page size are don't-care.
   function automatic logic vppn_match(logic [VPPN_W-1:0] a, logic [VPPN_W-1:0] b,
                                       logic [PS_W-1:0] ps);
      logic m;
      m = 1'b1;
      for (int i = 0; i < int'(VPPN_W); i++)
         if (i + PS_MIN >= int'(ps) && a[i] != b[i]) m = 1'b0;
      return m;
   endfunction

   function automatic logic odd_sel(logic [VPPN_W-1:0] vppn, logic bit12, logic [PS_W-1:0] ps);
      logic o;
      o = bit12;
      for (int i = 0; i < int'(VPPN_W); i++)
         if (i + PS_MIN + 1 == int'(ps)) o = vppn[i];
      return o;
   endfunction
endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit encoder with any-set and more-than-one-set flags.
module prio_enc #(
   parameter int unsigned N = 16,
   localparam int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         any,
   output logic         multi
);
   always_comb begin
      idx = '0;
      for (int i = int'(N) - 1; i >= 0; i--)
         if (req[i]) idx = W'(i);
   end

   assign any   = |req;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi = |(req & (req - 1'b1));
endmodule

// File: rtl/tlb_param.sv
// Fully associative TLB: two lookup ports, indexed/fill write, indexed read, INVTLB-style flush.
module tlb_param
   import tlb_pkg::*;
#(
   parameter int unsigned TLBNUM = 16,
   localparam int unsigned IDXW = $clog2(TLBNUM)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s0_req, s0_va_bit12,
   input  logic [VPPN_W-1:0] s0_vppn,
   input  logic [ASID_W-1:0] s0_asid,
   output logic              s0_rsp_valid, s0_found, s0_multi,
   output logic [IDXW-1:0]   s0_index,
   output logic [PPN_W-1:0]  s0_ppn,
   output logic [PS_W-1:0]   s0_ps,
   output logic [PLV_W-1:0]  s0_plv,
   output logic [MAT_W-1:0]  s0_mat,
   output logic              s0_d, s0_v,
   input  logic              s1_req, s1_va_bit12,
   input  logic [VPPN_W-1:0] s1_vppn,
   input  logic [ASID_W-1:0] s1_asid,
   output logic              s1_rsp_valid, s1_found, s1_multi,
   output logic [IDXW-1:0]   s1_index,
   output logic [PPN_W-1:0]  s1_ppn,
   output logic [PS_W-1:0]   s1_ps,
   output logic [PLV_W-1:0]  s1_plv,
   output logic [MAT_W-1:0]  s1_mat,
   output logic              s1_d, s1_v,
   input  logic              we, w_fill, w_e, w_g,
   input  logic [IDXW-1:0]   w_index,
   input  logic [VPPN_W-1:0] w_vppn,
   input  logic [PS_W-1:0]   w_ps,
   input  logic [ASID_W-1:0] w_asid,
   input  logic [PPN_W-1:0]  w_ppn0, w_ppn1,
   input  logic [PLV_W-1:0]  w_plv0, w_plv1,
   input  logic [MAT_W-1:0]  w_mat0, w_mat1,
   input  logic              w_d0, w_d1, w_v0, w_v1,
   output logic [IDXW-1:0]   fill_index,
   input  logic              r_req,
   input  logic [IDXW-1:0]   r_index,
   output logic              r_valid, r_e, r_g,
   output logic [VPPN_W-1:0] r_vppn,
   output logic [PS_W-1:0]   r_ps,
   output logic [ASID_W-1:0] r_asid,
   output logic [PPN_W-1:0]  r_ppn0, r_ppn1,
   output logic [PLV_W-1:0]  r_plv0, r_plv1,
   output logic [MAT_W-1:0]  r_mat0, r_mat1,
   output logic              r_d0, r_d1, r_v0, r_v1,
   input  logic              inv_req,
   input  logic [OP_W-1:0]   inv_op,
   input  logic [ASID_W-1:0] inv_asid,
   input  logic [VPPN_W-1:0] inv_vppn,
   output logic              inv_done, inv_err
);
   entry_t            tab_q [TLBNUM];
   entry_t            rd_q;
   logic [TLBNUM-1:0] e_q, e_d, inv_hit, inv_va, inv_as;
   logic [IDXW-1:0]   rr_q, free_idx, w_slot;
   logic              free_any, free_multi_unused;

   logic              s_req   [2];
   logic              s_bit12 [2];
   logic [VPPN_W-1:0] s_vppn  [2];
   logic [ASID_W-1:0] s_asid  [2];

   assign s_req[0]   = s0_req;
   assign s_req[1]   = s1_req;
   assign s_bit12[0] = s0_va_bit12;
   assign s_bit12[1] = s1_va_bit12;
   assign s_vppn[0]  = s0_vppn;
   assign s_vppn[1]  = s1_vppn;
   assign s_asid[0]  = s0_asid;
   assign s_asid[1]  = s1_asid;

   for (genvar p = 0; p < 2; p++) begin : g_srch
      logic [TLBNUM-1:0] hit;
      logic [IDXW-1:0]   idx, idx_q;
      logic              any, multi, valid_q, found_q, multi_q;
      logic [PS_W-1:0]   ps_q;
      page_t             page_q;

      always_comb begin
         hit = '0;
         for (int i = 0; i < int'(TLBNUM); i++)
            hit[i] = e_q[i] && (tab_q[i].g || tab_q[i].asid == s_asid[p])
                     && vppn_match(tab_q[i].vppn, s_vppn[p], tab_q[i].ps);
      end

      prio_enc #(.N(TLBNUM)) u_enc (.req(hit), .idx(idx), .any(any), .multi(multi));

      always_ff @(posedge clk) begin
         if (reset) begin
            valid_q <= 1'b0;
            found_q <= 1'b0;
            multi_q <= 1'b0;
            idx_q   <= '0;
            ps_q    <= '0;
            page_q  <= '0;
         end else begin
            valid_q <= s_req[p];
            if (s_req[p]) begin
               found_q <= any;
               multi_q <= multi;
               idx_q   <= idx;
               ps_q    <= any ? tab_q[idx].ps : '0;
               page_q  <= !any ? '0 :
                          (odd_sel(s_vppn[p], s_bit12[p], tab_q[idx].ps) ? tab_q[idx].p1
                                                                          : tab_q[idx].p0);
            end
         end
      end
   end

   assign s0_rsp_valid = g_srch[0].valid_q;
   assign s0_found     = g_srch[0].found_q;
   assign s0_multi     = g_srch[0].multi_q;
   assign s0_index     = g_srch[0].idx_q;
   assign s0_ps        = g_srch[0].ps_q;
   assign s0_ppn       = g_srch[0].page_q.ppn;
   assign s0_plv       = g_srch[0].page_q.plv;
   assign s0_mat       = g_srch[0].page_q.mat;
   assign s0_d         = g_srch[0].page_q.d;
   assign s0_v         = g_srch[0].page_q.v;
   assign s1_rsp_valid = g_srch[1].valid_q;
   assign s1_found     = g_srch[1].found_q;
   assign s1_multi     = g_srch[1].multi_q;
   assign s1_index     = g_srch[1].idx_q;
   assign s1_ps        = g_srch[1].ps_q;
   assign s1_ppn       = g_srch[1].page_q.ppn;
   assign s1_plv       = g_srch[1].page_q.plv;
   assign s1_mat       = g_srch[1].page_q.mat;
   assign s1_d         = g_srch[1].page_q.d;
   assign s1_v         = g_srch[1].page_q.v;

   // Free slots take priority; the round-robin pointer only matters when the table is full.
   prio_enc #(.N(TLBNUM)) u_fill (
      .req(~e_q), .idx(free_idx), .any(free_any), .multi(free_multi_unused)
   );
   assign fill_index = free_any ? free_idx : rr_q;
   assign w_slot     = w_fill ? fill_index : w_index;

   always_comb begin
      inv_va = '0;
      inv_as = '0;
      for (int i = 0; i < int'(TLBNUM); i++) begin
         inv_va[i] = vppn_match(tab_q[i].vppn, inv_vppn, tab_q[i].ps);
         inv_as[i] = tab_q[i].asid == inv_asid;
      end
   end

   always_comb begin
      inv_hit = '0;
      for (int i = 0; i < int'(TLBNUM); i++) begin
         case (inv_op)
            InvAll0, InvAll1:  inv_hit[i] = 1'b1;
            InvGlobal:         inv_hit[i] = tab_q[i].g;
            InvNonGlobal:      inv_hit[i] = !tab_q[i].g;
            InvAsid:           inv_hit[i] = !tab_q[i].g && inv_as[i];
            InvAsidVa:         inv_hit[i] = !tab_q[i].g && inv_as[i] && inv_va[i];
            InvGlobalOrAsidVa: inv_hit[i] = (tab_q[i].g || inv_as[i]) && inv_va[i];
            default:           inv_hit[i] = 1'b0;
         endcase
      end
   end

   // The write is applied after the flush so the written slot always keeps its new data.
   always_comb begin
      e_d = e_q;
      if (inv_req) e_d = e_q & ~inv_hit;
      if (we) e_d[w_slot] = w_e && ps_legal(w_ps);
   end

   always_ff @(posedge clk) begin
      if (!reset && we)
         tab_q[w_slot] <= '{vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                            p0: '{ppn: w_ppn0, plv: w_plv0, mat: w_mat0, d: w_d0, v: w_v0},
                            p1: '{ppn: w_ppn1, plv: w_plv1, mat: w_mat1, d: w_d1, v: w_v1}};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_q      <= '0;
         rr_q     <= '0;
         inv_done <= 1'b0;
         inv_err  <= 1'b0;
         r_valid  <= 1'b0;
         r_e      <= 1'b0;
         rd_q     <= '0;
      end else begin
         e_q      <= e_d;
         inv_done <= inv_req;
         inv_err  <= inv_req && inv_op > INV_OP_MAX;
         r_valid  <= r_req;
         if (we && w_fill) rr_q <= rr_q + 1'b1;
         if (r_req) begin
            r_e  <= e_q[r_index];
            rd_q <= tab_q[r_index];
         end
      end
   end

   assign r_vppn = rd_q.vppn;
   assign r_ps   = rd_q.ps;
   assign r_asid = rd_q.asid;
   assign r_g    = rd_q.g;
   assign r_ppn0 = rd_q.p0.ppn;
   assign r_plv0 = rd_q.p0.plv;
   assign r_mat0 = rd_q.p0.mat;
   assign r_d0   = rd_q.p0.d;
   assign r_v0   = rd_q.p0.v;
   assign r_ppn1 = rd_q.p1.ppn;
   assign r_plv1 = rd_q.p1.plv;
   assign r_mat1 = rd_q.p1.mat;
   assign r_d1   = rd_q.p1.d;
   assign r_v1   = rd_q.p1.v;
endmodule

// File: tb/tb_tlb_param.sv
// Randomized bench for tlb_param against a shift-based behavioural model of the table.
module tb_tlb_param;
   import tlb_pkg::*;
   localparam int N = 16;

   logic        clk, reset;
   logic        s0_req, s0_va_bit12, s1_req, s1_va_bit12;
   logic [18:0] s0_vppn, s1_vppn;
   logic [9:0]  s0_asid, s1_asid;
   logic        s0_rsp_valid, s0_found, s0_multi, s0_d, s0_v;
   logic        s1_rsp_valid, s1_found, s1_multi, s1_d, s1_v;
   logic [3:0]  s0_index, s1_index;
   logic [19:0] s0_ppn, s1_ppn;
   logic [5:0]  s0_ps, s1_ps;
   logic [1:0]  s0_plv, s0_mat, s1_plv, s1_mat;
   logic        we, w_fill, w_e, w_g, w_d0, w_d1, w_v0, w_v1;
   logic [3:0]  w_index, fill_index, r_index;
   logic [18:0] w_vppn, r_vppn, inv_vppn;
   logic [5:0]  w_ps, r_ps;
   logic [9:0]  w_asid, r_asid, inv_asid;
   logic [19:0] w_ppn0, w_ppn1, r_ppn0, r_ppn1;
   logic [1:0]  w_plv0, w_plv1, w_mat0, w_mat1, r_plv0, r_plv1, r_mat0, r_mat1;
   logic        r_req, r_valid, r_e, r_g, r_d0, r_d1, r_v0, r_v1;
   logic        inv_req, inv_done, inv_err;
   logic [4:0]  inv_op;

   tlb_param #(.TLBNUM(N)) dut (
      .clk(clk), .reset(reset),
      .s0_req(s0_req), .s0_va_bit12(s0_va_bit12), .s0_vppn(s0_vppn), .s0_asid(s0_asid),
      .s0_rsp_valid(s0_rsp_valid), .s0_found(s0_found), .s0_multi(s0_multi),
      .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps), .s0_plv(s0_plv), .s0_mat(s0_mat),
      .s0_d(s0_d), .s0_v(s0_v),
      .s1_req(s1_req), .s1_va_bit12(s1_va_bit12), .s1_vppn(s1_vppn), .s1_asid(s1_asid),
      .s1_rsp_valid(s1_rsp_valid), .s1_found(s1_found), .s1_multi(s1_multi),
      .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps), .s1_plv(s1_plv), .s1_mat(s1_mat),
      .s1_d(s1_d), .s1_v(s1_v),
      .we(we), .w_fill(w_fill), .w_e(w_e), .w_g(w_g), .w_index(w_index), .w_vppn(w_vppn),
      .w_ps(w_ps), .w_asid(w_asid), .w_ppn0(w_ppn0), .w_ppn1(w_ppn1), .w_plv0(w_plv0),
      .w_plv1(w_plv1), .w_mat0(w_mat0), .w_mat1(w_mat1), .w_d0(w_d0), .w_d1(w_d1),
      .w_v0(w_v0), .w_v1(w_v1), .fill_index(fill_index),
      .r_req(r_req), .r_index(r_index), .r_valid(r_valid), .r_e(r_e), .r_g(r_g),
      .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_ppn0(r_ppn0), .r_ppn1(r_ppn1),
      .r_plv0(r_plv0), .r_plv1(r_plv1), .r_mat0(r_mat0), .r_mat1(r_mat1),
      .r_d0(r_d0), .r_d1(r_d1), .r_v0(r_v0), .r_v1(r_v1),
      .inv_req(inv_req), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
      .inv_done(inv_done), .inv_err(inv_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference table
   bit m_e [N];
   int m_vppn [N], m_ps [N], m_asid [N];
   bit m_g [N];
   int m_ppn [N][2], m_plv [N][2], m_mat [N][2];
   bit m_d [N][2], m_v [N][2];
   int m_rr;

   logic [127:0] held_s [2];
   logic [127:0] held_r;
   bit exp_sv0, exp_sv1, exp_rv, exp_done, exp_err;

   int vpool [4] = '{'h12345, 'h7FC00, 'h0ABCD, 'h00333};
   int pspool [8] = '{12, 12, 13, 21, 22, 29, 30, 7};
   int apool [3] = '{5, 6, 9};

   task automatic check_eq(string tag, logic [127:0] got, logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int model_fill();
      for (int i = 0; i < N; i++)
         if (!m_e[i]) return i;
      return m_rr;
   endfunction

   function automatic bit va_eq(int i, int key);
      return (m_vppn[i] >> (m_ps[i] - 12)) == (key >> (m_ps[i] - 12));
   endfunction

   function automatic logic [127:0] model_lookup(int key, bit b12, int asid);
      int hit = -1;
      int cnt = 0;
      int odd;
      for (int i = 0; i < N; i++)
         if (m_e[i])
            if ((m_g[i] || m_asid[i] == asid) && va_eq(i, key)) begin
               if (hit < 0) hit = i;
               cnt++;
            end
      if (hit < 0) return '0;
      odd = (m_ps[hit] == 12) ? int'(b12) : ((key >> (m_ps[hit] - 13)) & 1);
      return 128'({1'b1, cnt > 1, 4'(hit), 20'(m_ppn[hit][odd]), 6'(m_ps[hit]),
                   2'(m_plv[hit][odd]), 2'(m_mat[hit][odd]), m_d[hit][odd], m_v[hit][odd]});
   endfunction

   function automatic logic [127:0] model_read(int i);
      return 128'({m_e[i], 19'(m_vppn[i]), 6'(m_ps[i]), 10'(m_asid[i]), m_g[i],
                   20'(m_ppn[i][0]), 2'(m_plv[i][0]), 2'(m_mat[i][0]), m_d[i][0], m_v[i][0],
                   20'(m_ppn[i][1]), 2'(m_plv[i][1]), 2'(m_mat[i][1]), m_d[i][1], m_v[i][1]});
   endfunction

   function automatic bit inv_match(int i);
      bit va = va_eq(i, int'(inv_vppn));
      bit as = m_asid[i] == int'(inv_asid);
      case (int'(inv_op))
         0, 1:    return 1'b1;
         2:       return m_g[i];
         3:       return !m_g[i];
         4:       return !m_g[i] && as;
         5:       return !m_g[i] && as && va;
         6:       return (m_g[i] || as) && va;
         default: return 1'b0;
      endcase
   endfunction

   // Apply one clock of stimulus, advance the model, then compare every output.
   task automatic cycle();
      int slot;
      if (reset) begin
         held_s[0] = '0; held_s[1] = '0; held_r = '0;
         exp_sv0 = 0; exp_sv1 = 0; exp_rv = 0; exp_done = 0; exp_err = 0;
         for (int i = 0; i < N; i++) m_e[i] = 0;
         m_rr = 0;
      end else begin
         exp_sv0 = s0_req; exp_sv1 = s1_req; exp_rv = r_req;
         if (s0_req) held_s[0] = model_lookup(int'(s0_vppn), s0_va_bit12, int'(s0_asid));
         if (s1_req) held_s[1] = model_lookup(int'(s1_vppn), s1_va_bit12, int'(s1_asid));
         if (r_req) held_r = model_read(int'(r_index));
         exp_done = inv_req;
         exp_err = inv_req && int'(inv_op) > 6;
         slot = w_fill ? model_fill() : int'(w_index);
         if (inv_req)
            for (int i = 0; i < N; i++)
               if (m_e[i] && inv_match(i)) m_e[i] = 0;
         if (we) begin
            m_e[slot] = w_e && int'(w_ps) >= 12 && int'(w_ps) <= 29;
            m_vppn[slot] = int'(w_vppn); m_ps[slot] = int'(w_ps);
            m_asid[slot] = int'(w_asid); m_g[slot] = w_g;
            m_ppn[slot][0] = int'(w_ppn0); m_ppn[slot][1] = int'(w_ppn1);
            m_plv[slot][0] = int'(w_plv0); m_plv[slot][1] = int'(w_plv1);
            m_mat[slot][0] = int'(w_mat0); m_mat[slot][1] = int'(w_mat1);
            m_d[slot][0] = w_d0; m_d[slot][1] = w_d1;
            m_v[slot][0] = w_v0; m_v[slot][1] = w_v1;
            if (w_fill) m_rr = (m_rr + 1) % N;
         end
      end
      @(posedge clk);
      #1;
      check_eq("s0_valid", 128'(s0_rsp_valid), 128'(exp_sv0));
      check_eq("s1_valid", 128'(s1_rsp_valid), 128'(exp_sv1));
      check_eq("s0_result", 128'({s0_found, s0_multi, s0_index, s0_ppn, s0_ps, s0_plv,
                                  s0_mat, s0_d, s0_v}), held_s[0]);
      check_eq("s1_result", 128'({s1_found, s1_multi, s1_index, s1_ppn, s1_ps, s1_plv,
                                  s1_mat, s1_d, s1_v}), held_s[1]);
      check_eq("r_valid", 128'(r_valid), 128'(exp_rv));
      check_eq("r_data", 128'({r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0, r_plv0, r_mat0, r_d0,
                               r_v0, r_ppn1, r_plv1, r_mat1, r_d1, r_v1}), held_r);
      check_eq("inv_done", 128'(inv_done), 128'(exp_done));
      check_eq("inv_err", 128'(inv_err), 128'(exp_err));
      check_eq("fill_index", 128'(fill_index), 128'(model_fill()));
      reset = 0; we = 0; inv_req = 0; s0_req = 0; s1_req = 0; r_req = 0;
   endtask

   task automatic set_write(int idx, bit fill, int vppn, int ps, int asid, bit g,
                            int ppn0, int ppn1);
      we = 1; w_fill = fill; w_index = 4'(idx); w_e = 1; w_vppn = 19'(vppn);
      w_ps = 6'(ps); w_asid = 10'(asid); w_g = g; w_ppn0 = 20'(ppn0); w_ppn1 = 20'(ppn1);
      w_plv0 = 2'd0; w_plv1 = 2'd3; w_mat0 = 2'd1; w_mat1 = 2'd2;
      w_d0 = 1; w_d1 = 0; w_v0 = 1; w_v1 = 1;
   endtask

   task automatic rand_write();
      we = 1; w_fill = 1'($urandom_range(0, 1)); w_index = 4'($urandom_range(0, N - 1));
      w_e = ($urandom_range(0, 7) != 0); w_vppn = 19'(vpool[$urandom_range(0, 3)]);
      w_ps = 6'(pspool[$urandom_range(0, 7)]); w_asid = 10'(apool[$urandom_range(0, 2)]);
      w_g = 1'($urandom_range(0, 1));
      w_ppn0 = 20'($urandom); w_ppn1 = 20'($urandom);
      w_plv0 = 2'($urandom); w_plv1 = 2'($urandom); w_mat0 = 2'($urandom); w_mat1 = 2'($urandom);
      w_d0 = 1'($urandom); w_d1 = 1'($urandom); w_v0 = 1'($urandom); w_v1 = 1'($urandom);
   endtask

   function automatic logic [18:0] rand_key();
      int k = vpool[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 1) k = k ^ (1 << $urandom_range(0, 18));
      return 19'(k);
   endfunction

   initial begin
      reset = 1; we = 0; w_fill = 0; inv_req = 0; inv_op = '0; inv_asid = '0; inv_vppn = '0;
      s0_req = 0; s1_req = 0; r_req = 0; r_index = '0;
      s0_vppn = '0; s1_vppn = '0; s0_asid = '0; s1_asid = '0; s0_va_bit12 = 0; s1_va_bit12 = 0;
      set_write(0, 0, 0, 12, 0, 0, 0, 0);
      we = 0;
      for (int i = 0; i < N; i++) m_e[i] = 0;
      m_rr = 0;
      cycle();

      // Lookup on an empty table
      s0_req = 1; s0_vppn = 19'h12345; s0_asid = 10'd1;
      cycle();
      check_eq("empty_valid", 128'(s0_rsp_valid), 128'd1);
      check_eq("empty_found", 128'(s0_found), 128'd0);
      check_eq("empty_fill", 128'(fill_index), 128'd0);

      // 18 fill writes from reset: 0..15 then round-robin 0, 1
      reset = 1; cycle();
      for (int k = 0; k < 18; k++) begin
         check_eq("fill_seq", 128'(fill_index), 128'(k < 16 ? k : k - 16));
         set_write(0, 1, 'h40000 + k, 12, 1, 0, k, k + 100);
         cycle();
      end

      reset = 1; cycle();
      set_write(3, 0, 'h12345, 12, 5, 0, 'hAAAAA, 'hBBBBB);
      cycle();
      s1_req = 1; s1_vppn = 19'h12345; s1_va_bit12 = 1; s1_asid = 10'd5;
      cycle();
      check_eq("odd4k_found", 128'(s1_found), 128'd1);
      check_eq("odd4k_index", 128'(s1_index), 128'd3);
      check_eq("odd4k_ppn", 128'(s1_ppn), 128'hBBBBB);
      check_eq("odd4k_ps", 128'(s1_ps), 128'd12);
      s1_req = 1; s1_asid = 10'd6;
      cycle();
      check_eq("asid_miss", 128'(s1_found), 128'd0);

      set_write(0, 0, 'h7FC00, 22, 0, 1, 'h22222, 'h11111);
      cycle();
      s0_req = 1; s0_vppn = 19'h7FE55; s0_asid = 10'd9;
      cycle();
      check_eq("4m_found", 128'(s0_found), 128'd1);
      check_eq("4m_odd_ppn", 128'(s0_ppn), 128'h11111);
      s0_req = 1; s0_vppn = 19'h7FA00;
      cycle();
      check_eq("4m_miss", 128'(s0_found), 128'd0);

      // Selective flush: only the non-global entry of ASID 5 goes
      reset = 1; cycle();
      set_write(1, 0, 'h12345, 12, 5, 0, 1, 2); cycle();
      set_write(2, 0, 'h12345, 12, 7, 1, 3, 4); cycle();
      inv_req = 1; inv_op = 5'd5; inv_asid = 10'd5; inv_vppn = 19'h12345;
      cycle();
      check_eq("inv5_done", 128'(inv_done), 128'd1);
      r_req = 1; r_index = 4'd1; cycle();
      check_eq("inv5_idx1", 128'(r_e), 128'd0);
      r_req = 1; r_index = 4'd2; cycle();
      check_eq("inv5_idx2", 128'(r_e), 128'd1);
      inv_req = 1; inv_op = 5'd7; cycle();
      check_eq("inv7_err", 128'(inv_err), 128'd1);
      r_req = 1; r_index = 4'd2; cycle();
      check_eq("inv7_keep", 128'(r_e), 128'd1);

      set_write(2, 0, 'h00333, 13, 2, 0, 5, 6);
      inv_req = 1; inv_op = 5'd0;
      cycle();
      r_req = 1; r_index = 4'd2; cycle();
      check_eq("wr_inv_keep", 128'(r_e), 128'd1);
      check_eq("wr_inv_fill", 128'(fill_index), 128'd0);
      set_write(4, 0, 'h0ABCD, 12, 3, 0, 7, 8); cycle();
      set_write(9, 0, 'h0ABCD, 12, 3, 0, 7, 8); cycle();
      s0_req = 1; s0_vppn = 19'h0ABCD; s0_asid = 10'd3; cycle();
      check_eq("multi_index", 128'(s0_index), 128'd4);
      check_eq("multi_flag", 128'(s0_multi), 128'd1);

      for (int c = 0; c < 800; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         s0_req = 1'($urandom_range(0, 1)); s0_vppn = rand_key();
         s0_va_bit12 = 1'($urandom); s0_asid = 10'(apool[$urandom_range(0, 2)]);
         s1_req = 1'($urandom_range(0, 1)); s1_vppn = rand_key();
         s1_va_bit12 = 1'($urandom); s1_asid = 10'(apool[$urandom_range(0, 2)]);
         if ($urandom_range(0, 9) < 4) rand_write();
         inv_req = ($urandom_range(0, 19) == 0);
         inv_op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(2, 7));
         inv_asid = 10'(apool[$urandom_range(0, 2)]); inv_vppn = rand_key();
         r_req = 1'($urandom_range(0, 1)); r_index = 4'($urandom_range(0, N - 1));
         cycle();
      end

      // Reset must win over every strobe in the same cycle
      rand_write(); reset = 1; inv_req = 1; inv_op = 5'd0; s0_req = 1; s1_req = 1; r_req = 1;
      cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/tlb_param.md
TLB_PARAM -- requirements
Module: tlb_param

Interface
REQ-001 TLBNUM, 16, entry count; power of two, 4..64; IDXW = clog2(TLBNUM).
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 sN_req / sN_vppn / sN_va_bit12 / sN_asid (N=0,1)  in  1/19/1/10  lookup request and key.
REQ-005 sN_rsp_valid / sN_found / sN_multi / sN_index  out  1/1/1/IDXW  lookup status.
REQ-006 sN_ppn / sN_ps / sN_plv / sN_mat / sN_d / sN_v  out  20/6/2/2/1/1  translated page fields.
REQ-007 we / w_fill / w_index  in  1/1/IDXW  write strobe, hardware-chosen-index select, explicit index.
REQ-008 w_e, w_vppn, w_ps, w_asid, w_g  in  1/19/6/10/1  entry tag fields.
REQ-009 w_ppn0/1, w_plv0/1, w_mat0/1, w_d0/1, w_v0/1  in  20/2/2/1/1  even/odd page fields.
REQ-010 fill_index  out  IDXW  index the next fill write uses (registered).
REQ-011 r_req / r_index  in  1/IDXW; r_valid plus r_e..r_v1 (same widths as w_*)  out  registered read.
REQ-012 inv_req / inv_op / inv_asid / inv_vppn  in  1/5/10/19; inv_done / inv_err  out  1/1.

Function
REQ-013 Entry i matches (vppn,asid) when e=1, (g=1 or asid equal), and vppn[18:ps-12] equal; lower bits ignored; legal ps 12..29.
REQ-014 Odd page selected by (ps==12 ? va_bit12 : vppn[ps-13]); ppn/plv/mat/d/v from that half; sN_ps = entry ps.
REQ-015 sN_req at cycle t samples key and pre-edge table; results at t+1 with sN_rsp_valid high exactly one cycle; result registers hold until next sN_req.
REQ-016 Miss: found=0, multi=0, all other result fields 0.
REQ-017 Multiple matches: lowest matching index reported, sN_multi=1.
REQ-018 we commits entry at edge to (w_fill ? fill_index : w_index); w_ps outside 12..29 stores entry with e=0.
REQ-019 fill_index = lowest index with e=0 if any; else round-robin pointer; pointer increments mod TLBNUM on every fill write.
REQ-020 Search/read in same cycle as write/invalidate returns pre-edge contents (no bypass).
REQ-021 inv_req at t clears e of matching entries at that edge; inv_done pulses at t+1.
REQ-022 inv_op: 0/1 all; 2 g=1; 3 g=0; 4 g=0&asid; 5 g=0&asid&va; 6 (g=1|asid)&va; va match per REQ-013 using inv_vppn.
REQ-023 inv_op>6: table unchanged, inv_done and inv_err both pulse at t+1.
REQ-024 we and inv_req same cycle: written entry takes write data; all other matching entries invalidated.
REQ-025 r_req at t: r_* from r_index at t+1, r_valid one-cycle pulse, fields held until next r_req.

Reset
REQ-026 Reset clears all e bits, round-robin pointer, all result registers, sN_rsp_valid, r_valid, inv_done, inv_err; fill_index=0.
REQ-027 Reset overrides we, inv_req, sN_req, r_req in the same cycle; payload arrays are not reset.

Structure
REQ-028 Shared package tlb_pkg: PS_4K=12, PS_4M=22, PS_MIN=12, PS_MAX=29, INVTLB op codes 0..6, entry field widths.
REQ-029 One sub-module prio_enc (TLBNUM-to-IDXW lowest-set-bit encoder with any/multi flags), instanced for both lookups and fill selection.

Verification
REQ-030 Reset, s0 lookup vppn 0x12345 -> t+1 rsp_valid=1, found=0, fill_index=0.
REQ-031 Write idx3 vppn 0x12345 ps12 asid5 g0 ppn0 0xAAAAA ppn1 0xBBBBB v0=v1=1; s1 lookup bit12=1 asid5 -> found, index 3, ppn 0xBBBBB, ps 12; asid6 -> miss.
REQ-032 Write idx0 ps22 vppn 0x7FC00 g1; lookup vppn 0x7FE55 asid 9 -> hit, odd page; vppn 0x7FA00 -> miss.
REQ-033 From reset, 18 writes w_fill=1 -> indices 0..15, then 0, 1.
REQ-034 idx1 (g0 asid5) and idx2 (g1), both vppn 0x12345; inv op5 asid5 va 0x12345 -> only idx1 cleared, inv_done at t+1; op7 -> inv_err=1, no change.
REQ-035 we idx2 e=1 with inv op0 same cycle -> only idx2 valid; identical entries at idx4, idx9 -> index 4, multi=1.
